// File: rtl/frame_writer.sv
// Pixel stream to byte-addressed frame memory writer (3 bytes/pixel, BMP-style rows).
// Optional row padding to a 4-byte multiple is enabled by defining FRAME_WRITER_PAD_EN.
module frame_writer #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       pixel,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        state_dbg
);

  // Handshakes: a pixel moves on in_valid && in_ready; a byte moves on
  // mem_we && mem_ready, and mem_we/mem_addr/mem_data hold until then.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_B0   = 3'd1;
  localparam logic [2:0] S_B1   = 3'd2;
  localparam logic [2:0] S_B2   = 3'd3;
`ifdef FRAME_WRITER_PAD_EN
  localparam logic [2:0] S_PAD  = 3'd4;
  localparam int PAD_BYTES = (4 - ((3 * WIDTH) % 4)) % 4;
`endif
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);

  logic [23:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              in_ready_r;
  logic [2:0]        state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic              fresh;
`ifdef FRAME_WRITER_PAD_EN
  logic [1:0]        pad_cnt;
`endif

  logic        push, pop, accept, has_next, end_of_row, last_row;
  logic [23:0] head;

  assign accept     = mem_we && mem_ready;
  assign push       = in_valid && in_ready_r;
  assign pop        = (state == S_B2) && accept;
  assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
  assign head       = fifo_mem[rd_ptr];
  assign end_of_row = (col == COL_W'(WIDTH - 1));
  assign last_row   = (row == ROW_W'(HEIGHT - 1));
  // Whether another pixel is available once this cycle's pop has happened.
  assign has_next   = pop ? (count > CNT_W'(1)) : (count != '0);

  assign in_ready   = in_ready_r;
  assign mem_addr   = addr;
  assign busy       = (state != S_IDLE) || (count != '0);
  assign frame_done = (state == S_DONE);
  assign state_dbg  = state;

  always_comb begin
    mem_we = (state == S_B0) || (state == S_B1) || (state == S_B2);
`ifdef FRAME_WRITER_PAD_EN
    if (state == S_PAD) mem_we = 1'b1;
`endif
  end

  always_comb begin
    mem_data = 8'h00;
    case (state)
      S_B0:    mem_data = head[7:0];
      S_B1:    mem_data = head[15:8];
      S_B2:    mem_data = head[23:16];
      default: mem_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !frame_start) fifo_mem[wr_ptr] <= pixel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      in_ready_r <= 1'b1;
    end else if (frame_start) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      in_ready_r <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      in_ready_r <= (count_nxt != CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
      fresh <= 1'b1;
`ifdef FRAME_WRITER_PAD_EN
      pad_cnt <= '0;
`endif
    end else if (frame_start) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
      fresh <= 1'b1;
`ifdef FRAME_WRITER_PAD_EN
      pad_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (count != '0) begin
          state <= S_B0;
          if (fresh) begin
            addr  <= base_addr;
            fresh <= 1'b0;
          end
        end
        S_B0: if (accept) begin
          addr  <= addr + 1'b1;
          state <= S_B1;
        end
        S_B1: if (accept) begin
          addr  <= addr + 1'b1;
          state <= S_B2;
        end
        S_B2: if (accept) begin
          addr <= addr + 1'b1;
          if (!end_of_row) begin
            col   <= col + 1'b1;
            state <= has_next ? S_B0 : S_IDLE;
          end else begin
            col <= '0;
`ifdef FRAME_WRITER_PAD_EN
            if (PAD_BYTES != 0) state <= S_PAD;
            else
`endif
            begin
              row   <= last_row ? '0 : row + 1'b1;
              state <= last_row ? S_DONE : (has_next ? S_B0 : S_IDLE);
            end
          end
        end
`ifdef FRAME_WRITER_PAD_EN
        S_PAD: if (accept) begin
          addr <= addr + 1'b1;
          if (pad_cnt == 2'(PAD_BYTES - 1)) begin
            pad_cnt <= '0;
            row     <= last_row ? '0 : row + 1'b1;
            state   <= last_row ? S_DONE : (has_next ? S_B0 : S_IDLE);
          end else begin
            pad_cnt <= pad_cnt + 1'b1;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
          fresh <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
